frame_sequencer: RTL and testbench

Sound-unit frame sequencer and channel-1 sweep scheduler. It divides the system clock into the 512 Hz frame-step rate and emits single-cycle length, sweep and envelope strobes for all channels. It also owns the channel-1 sweep period timer: it tells the frequency-sweep datapath when to load its shadow register and when to apply a sweep step, and it disables channel 1 on sweep overflow. It sits between the sound register file (NR10, NR14 trigger, NR52) and the per-channel datapaths.

---
 rtl/frame_sequencer.sv | 146 ++++++++++++++
 tb/tb_frame_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer: 512 Hz frame-step divider with length/sweep/envelope
// strobes, plus the channel-1 sweep period timer and overflow kill.
module frame_sequencer #(
  parameter int unsigned CLK_PER_STEP = 32768
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sound_en,
  input  logic [7:0] NR10,
  input  logic       trigger,
  input  logic       sweep_overflow,
  output logic [2:0] step,
  output logic       length_tick,
  output logic       sweep_tick,
  output logic       envelope_tick,
  output logic       sweep_reload,
  output logic       sweep_update,
  output logic       sweep_active,
  output logic       ch1_kill
);

  localparam int unsigned PW = (CLK_PER_STEP > 1) ? $clog2(CLK_PER_STEP) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_STEP - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    step_q, step_d;
  logic [3:0]    timer_q, timer_d;
  logic          len_q, len_d;
  logic          swt_q, swt_d;
  logic          env_q, env_d;
  logic          reload_q, reload_d;
  logic          arm_q, arm_d;
  logic          update_q, update_d;
  logic          active_q, active_d;
  logic          kill_q, kill_d;

  logic [2:0] period;
  logic [3:0] eff_period;
  logic       sweep_cfg;
  logic       tc;
  logic       sweep_edge;

  // Direction and the top NR10 bit belong to the frequency datapath.
  logic unused_nr10;
  assign unused_nr10 = ^{NR10[7], NR10[3]};

  // NR10 decode: period 0 reloads the timer with 8.
  always_comb begin
    period     = NR10[6:4];
    eff_period = (period == 3'd0) ? 4'd8 : {1'b0, period};
    sweep_cfg  = (period != 3'd0) || (NR10[2:0] != 3'd0);
    tc         = (presc_q == PRESC_LAST);
    sweep_edge = tc && (step_q[1:0] == 2'b10);
  end

  // Next-state: prescaler, step strobes, sweep timer, trigger and overflow.
  always_comb begin
    presc_d  = presc_q;
    step_d   = step_q;
    timer_d  = timer_q;
    len_d    = 1'b0;
    swt_d    = 1'b0;
    env_d    = 1'b0;
    reload_d = 1'b0;
    arm_d    = 1'b0;
    update_d = 1'b0;
    active_d = active_q;
    kill_d   = 1'b0;

    if (!sound_en) begin
      presc_d  = '0;
      step_d   = '0;
      timer_d  = '0;
      active_d = 1'b0;
    end else begin
      presc_d = tc ? '0 : presc_q + PW'(1);
      if (tc) begin
        step_d = step_q + 3'd1;
        len_d  = ~step_q[0];
        swt_d  = (step_q[1:0] == 2'b10);
        env_d  = (step_q == 3'd7);
      end

      update_d = arm_q && active_q && (period != 3'd0);

      if (trigger) begin
        // Trigger wins over a coincident decrement and masks overflow.
        timer_d  = eff_period;
        active_d = sweep_cfg;
        reload_d = 1'b1;
      end else begin
        if (update_q && sweep_overflow) begin
          active_d = 1'b0;
          kill_d   = 1'b1;
        end
        if (sweep_edge) begin
          if (timer_q > 4'd1) begin
            timer_d = timer_q - 4'd1;
          end else begin
            timer_d = eff_period;
            arm_d   = 1'b1;
          end
        end
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q  <= '0;
      step_q   <= '0;
      timer_q  <= '0;
      len_q    <= 1'b0;
      swt_q    <= 1'b0;
      env_q    <= 1'b0;
      reload_q <= 1'b0;
      arm_q    <= 1'b0;
      update_q <= 1'b0;
      active_q <= 1'b0;
      kill_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      step_q   <= step_d;
      timer_q  <= timer_d;
      len_q    <= len_d;
      swt_q    <= swt_d;
      env_q    <= env_d;
      reload_q <= reload_d;
      arm_q    <= arm_d;
      update_q <= update_d;
      active_q <= active_d;
      kill_q   <= kill_d;
    end
  end

  assign step          = step_q;
  assign length_tick   = len_q;
  assign sweep_tick    = swt_q;
  assign envelope_tick = env_q;
  assign sweep_reload  = reload_q;
  assign sweep_update  = update_q;
  assign sweep_active  = active_q;
  assign ch1_kill      = kill_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with CLK_PER_STEP=4.
module tb_frame_sequencer;

  localparam int unsigned CPS = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       sound_en;
  logic [7:0] NR10;
  logic       trigger;
  logic       sweep_overflow;
  logic [2:0] step;
  logic       length_tick;
  logic       sweep_tick;
  logic       envelope_tick;
  logic       sweep_reload;
  logic       sweep_update;
  logic       sweep_active;
  logic       ch1_kill;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  frame_sequencer #(.CLK_PER_STEP(CPS)) dut (
    .clock          (clock),
    .reset          (reset),
    .sound_en       (sound_en),
    .NR10           (NR10),
    .trigger        (trigger),
    .sweep_overflow (sweep_overflow),
    .step           (step),
    .length_tick    (length_tick),
    .sweep_tick     (sweep_tick),
    .envelope_tick  (envelope_tick),
    .sweep_reload   (sweep_reload),
    .sweep_update   (sweep_update),
    .sweep_active   (sweep_active),
    .ch1_kill       (ch1_kill)
  );

  always #5 clock = ~clock;

  // Advance one cycle; sample 1 time unit after the edge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Hold reset for a few edges then release; cycle 0 is the first
  // cycle after release.
  task automatic start(input logic [7:0] nr10);
    reset          = 1'b1;
    sound_en       = 1'b1;
    trigger        = 1'b0;
    sweep_overflow = 1'b0;
    NR10           = nr10;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all(input string sc, input logic [2:0] s, input logic l,
                         input logic sw, input logic e, input logic r,
                         input logic u, input logic a, input logic k);
    chk({sc, ":step"},          8'(step),          8'(s));
    chk({sc, ":length_tick"},   8'(length_tick),   8'(l));
    chk({sc, ":sweep_tick"},    8'(sweep_tick),    8'(sw));
    chk({sc, ":envelope_tick"}, 8'(envelope_tick), 8'(e));
    chk({sc, ":sweep_reload"},  8'(sweep_reload),  8'(r));
    chk({sc, ":sweep_update"},  8'(sweep_update),  8'(u));
    chk({sc, ":sweep_active"},  8'(sweep_active),  8'(a));
    chk({sc, ":ch1_kill"},      8'(ch1_kill),      8'(k));
  endtask

  initial begin
    // Reset state while reset is held.
    reset = 1'b1; sound_en = 1'b1; trigger = 1'b0; sweep_overflow = 1'b0; NR10 = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 1: free-running strobes after reset release.
    start(8'h00);
    while (cyc <= 40) begin
      chk_all("s1", 3'((cyc / 4) % 8), (cyc % 8 == 4), (cyc % 16 == 12),
              (cyc % 32 == 0) && (cyc > 0), 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle();
    end

    // 2: period 2, trigger at cycle 1; update at 29.
    start(8'h21);
    while (cyc <= 40) begin
      chk_all("s2", 3'((cyc / 4) % 8), (cyc % 8 == 4), (cyc % 16 == 12),
              (cyc % 32 == 0) && (cyc > 0), (cyc == 2), (cyc == 29),
              (cyc >= 2), 1'b0);
      trigger = (cyc == 1);
      next_cycle();
    end

    // 3: overflow during the update cycle kills channel 1; a stray
    // overflow at cycle 20 is ignored.
    start(8'h21);
    while (cyc <= 64) begin
      chk_all("s3", 3'((cyc / 4) % 8), (cyc % 8 == 4), (cyc % 16 == 12),
              (cyc % 32 == 0) && (cyc > 0), (cyc == 2), (cyc == 29),
              (cyc >= 2) && (cyc < 30), (cyc == 30));
      trigger        = (cyc == 1);
      sweep_overflow = (cyc == 29) || (cyc == 20);
      next_cycle();
    end
    sweep_overflow = 1'b0;

    // 4: period 0 loads 8 and never updates; a period change mid-flight
    // only shows at the reload on the 8th sweep tick (update at 125).
    start(8'h01);
    while (cyc <= 130) begin
      chk_all("s4", 3'((cyc / 4) % 8), (cyc % 8 == 4), (cyc % 16 == 12),
              (cyc % 32 == 0) && (cyc > 0), (cyc == 2), (cyc == 125),
              (cyc >= 2), 1'b0);
      trigger = (cyc == 1);
      if (cyc == 100) NR10 = 8'h11;
      next_cycle();
    end

    // 5: period 1; retrigger on the sweep-tick edge suppresses the
    // update that would otherwise appear at 13.
    start(8'h11);
    while (cyc <= 32) begin
      chk_all("s5", 3'((cyc / 4) % 8), (cyc % 8 == 4), (cyc % 16 == 12),
              (cyc % 32 == 0) && (cyc > 0), (cyc == 2) || (cyc == 12),
              (cyc == 29), (cyc >= 2), 1'b0);
      trigger = (cyc == 1) || (cyc == 11);
      next_cycle();
    end

    // 7: trigger plus overflow in the update cycle: no kill.
    start(8'h11);
    while (cyc <= 32) begin
      chk_all("s7", 3'((cyc / 4) % 8), (cyc % 8 == 4), (cyc % 16 == 12),
              (cyc % 32 == 0) && (cyc > 0), (cyc == 2) || (cyc == 14),
              (cyc == 13) || (cyc == 29), (cyc >= 2), 1'b0);
      trigger        = (cyc == 1) || (cyc == 13);
      sweep_overflow = (cyc == 13);
      next_cycle();
    end
    sweep_overflow = 1'b0;

    // 6: sound_en low (v=0) or reset high (v=1) during cycles 21..23.
    for (int v = 0; v < 2; v++) begin
      start(8'h11);
      while (cyc <= 36) begin
        chk_all(v == 0 ? "s6en" : "s6rst",
                (cyc < 22) ? 3'((cyc / 4) % 8) : (cyc < 28) ? 3'd0 : 3'(1 + (cyc - 28) / 4),
                (cyc == 4) || (cyc == 12) || (cyc == 20) || (cyc == 28) || (cyc == 36),
                (cyc == 12) || (cyc == 36), 1'b0, (cyc == 2), (cyc == 13),
                (cyc >= 2) && (cyc < 22), 1'b0);
        trigger = (cyc == 1) || (cyc == 22);
        if (v == 0) sound_en = !((cyc >= 21) && (cyc <= 23));
        else        reset    = (cyc >= 21) && (cyc <= 23);
        next_cycle();
      end
      sound_en = 1'b1;
      reset    = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
